// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// vga_sync_gen_if : video timing bundle (syncs, coordinates, active qualifier)
// Revision: 1.0
// ============================================================================
interface vga_sync_gen_if;
    logic       hsync;
    logic       vsync;
    logic [9:0] x_px;
    logic [9:0] y_px;
    logic       activevideo;

    modport master (
        output hsync,
        output vsync,
        output x_px,
        output y_px,
        output activevideo
    );

    modport slave (
        input hsync,
        input vsync,
        input x_px,
        input y_px,
        input activevideo
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// vga_sync_gen : free-running VGA timing generator, 640x480 @ 72 Hz default
// Revision: 1.0
// ============================================================================
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 24,
    parameter int unsigned H_SYNC    = 40,
    parameter int unsigned H_BP      = 128,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 9,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BP      = 28,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  wire logic           px_clk,
    input  wire logic           reset,
    vga_sync_gen_if.master      vid
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_ACTIVE  = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACTIVE  = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       w_hs_on;
    logic       w_vs_on;

    // The vertical counter only advances on the edge where the line wraps.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == c_H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_q == c_V_LAST) ? 10'd0 : vc_q + 10'd1;
        end
    end

    always_ff @(posedge px_clk or negedge reset) begin
        if (!reset) begin
            hc_q <= 10'd0;
            vc_q <= 10'd0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign w_hs_on = (hc_q >= c_HS_START) && (hc_q <= c_HS_END);
    assign w_vs_on = (vc_q >= c_VS_START) && (vc_q <= c_VS_END);

    assign vid.x_px        = hc_q;
    assign vid.y_px        = vc_q;
    assign vid.activevideo = (hc_q < c_H_ACTIVE) && (vc_q < c_V_ACTIVE);
    assign vid.hsync       = w_hs_on ? HSYNC_POL : ~HSYNC_POL;
    assign vid.vsync       = w_vs_on ? VSYNC_POL : ~VSYNC_POL;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_gen : directed checks of default and reduced-size timing
// Revision: 1.0
// ============================================================================
module tb_vga_sync_gen;

    logic px_clk = 1'b0;
    logic rst_a  = 1'b0;
    logic rst_b  = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    vga_sync_gen_if vid_a ();
    vga_sync_gen_if vid_b ();

    vga_sync_gen u_dut_a (
        .px_clk (px_clk),
        .reset  (rst_a),
        .vid    (vid_a)
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b0)
    ) u_dut_b (
        .px_clk (px_clk),
        .reset  (rst_b),
        .vid    (vid_b)
    );

    always #5 px_clk = ~px_clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge px_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        int ex, ey;
        int av_cnt, hs_cnt, vs_cnt, hs_rises, last_hs_rise, hs_period;
        int vs_falls, last_vs_fall, vs_period;
        logic prev_hs, prev_vs;

        // ---------------- reset state, both instances ----------------
        tick(3);
        chk("rst_x", int'(vid_a.x_px), 0);
        chk("rst_y", int'(vid_a.y_px), 0);
        chk("rst_av", int'(vid_a.activevideo), 1);
        chk("rst_hs", int'(vid_a.hsync), 1);
        chk("rst_vs", int'(vid_a.vsync), 1);
        chk("rstb_hs", int'(vid_b.hsync), 0);

        // ---------------- default timing, first line ----------------
        rst_a = 1'b1;
        tick();
        chk("first_x", int'(vid_a.x_px), 1);
        tick(638);
        chk("x639", int'(vid_a.x_px), 639);
        chk("av639", int'(vid_a.activevideo), 1);
        tick();
        chk("x640", int'(vid_a.x_px), 640);
        chk("av640", int'(vid_a.activevideo), 0);
        tick(23);
        chk("hs663", int'(vid_a.hsync), 1);
        tick();
        chk("x664", int'(vid_a.x_px), 664);
        chk("hs664", int'(vid_a.hsync), 0);
        cnt = 0;
        while (vid_a.hsync == 1'b0 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("hs_low_len", cnt, 40);
        chk("hs_rise_x", int'(vid_a.x_px), 704);
        tick(127);
        chk("x831", int'(vid_a.x_px), 831);
        chk("y_line0", int'(vid_a.y_px), 0);
        tick();
        chk("wrap_x", int'(vid_a.x_px), 0);
        chk("wrap_y", int'(vid_a.y_px), 1);
        chk("av_line1", int'(vid_a.activevideo), 1);
        chk("vs_line1", int'(vid_a.vsync), 1);

        // ---------------- asynchronous mid-line reset ----------------
        tick(300);
        chk("pre_rst_x", int'(vid_a.x_px), 300);
        #2 rst_a = 1'b0;
        #1;
        chk("async_x", int'(vid_a.x_px), 0);
        chk("async_y", int'(vid_a.y_px), 0);
        chk("async_av", int'(vid_a.activevideo), 1);
        rst_a = 1'b1;
        tick();
        chk("restart_x", int'(vid_a.x_px), 1);
        chk("restart_y", int'(vid_a.y_px), 0);
        tick(663);
        chk("restart_x664", int'(vid_a.x_px), 664);
        chk("restart_hs", int'(vid_a.hsync), 0);

        // ---------------- reduced geometry: 15x8, two full frames ----------------
        chk("rstb_x", int'(vid_b.x_px), 0);
        rst_b = 1'b1;
        ex = 0; ey = 0;
        av_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        hs_rises = 0; last_hs_rise = 0; hs_period = 0;
        vs_falls = 0; last_vs_fall = 0; vs_period = 0;
        prev_hs = vid_b.hsync;
        prev_vs = vid_b.vsync;
        for (int t = 1; t <= 240; t++) begin
            tick();
            if (ex == 14) begin
                ex = 0;
                ey = (ey == 7) ? 0 : ey + 1;
            end else begin
                ex = ex + 1;
            end
            chk("b_x", int'(vid_b.x_px), ex);
            chk("b_y", int'(vid_b.y_px), ey);
            chk("b_av", int'(vid_b.activevideo), int'(ex < 8 && ey < 4));
            chk("b_hs", int'(vid_b.hsync), int'(ex >= 10 && ex <= 12));
            chk("b_vs", int'(vid_b.vsync), int'(!(ey >= 5 && ey <= 6)));
            if (t <= 120) begin
                av_cnt += int'(vid_b.activevideo);
                hs_cnt += int'(vid_b.hsync);
                vs_cnt += int'(!vid_b.vsync);
            end
            if (vid_b.hsync && !prev_hs) begin
                if (hs_rises > 0) hs_period = t - last_hs_rise;
                hs_rises++;
                last_hs_rise = t;
            end
            if (!vid_b.vsync && prev_vs) begin
                if (vs_falls > 0) vs_period = t - last_vs_fall;
                vs_falls++;
                last_vs_fall = t;
            end
            prev_hs = vid_b.hsync;
            prev_vs = vid_b.vsync;
        end
        chk("b_av_per_frame", av_cnt, 32);
        chk("b_hs_per_frame", hs_cnt, 24);
        chk("b_vs_per_frame", vs_cnt, 30);
        chk("b_hs_rises", hs_rises, 16);
        chk("b_hs_period", hs_period, 15);
        chk("b_vs_falls", vs_falls, 2);
        chk("b_vs_period", vs_period, 120);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
